twin_stick_mapper: RTL and testbench

// - Converts MiSTer joystick inputs into the 4-bit direction vectors used by the williams2 core.

---
 rtl/twin_stick_mapper.sv | 193 +++++++++++++++++++
 tb/tb_twin_stick_mapper.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twin_stick_mapper.sv
// Maps MiSTer d-pad and analog sticks to williams2 run/aim direction nibbles, with
// per-axis hysteresis, SOCD neutralisation, debounce and last-active-player tracking.
module twin_stick_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int THRESH_ON   = 40,
    parameter int THRESH_OFF  = 24,
    parameter int DEBOUNCE    = 3,
    parameter int PW          = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     sample_ce,
    input  logic [2*NUM_PLAYERS-1:0]  mode,
    input  logic [32*NUM_PLAYERS-1:0] joy_dig,
    input  logic [16*NUM_PLAYERS-1:0] joy_l_analog,
    input  logic [16*NUM_PLAYERS-1:0] joy_r_analog,
    output logic [4*NUM_PLAYERS-1:0]  run,
    output logic [4*NUM_PLAYERS-1:0]  aim,
    output logic [PW-1:0]             active_player,
    output logic                      activity
);

    typedef enum logic [1:0] {CENTER, POS, NEG} axis_e;

    localparam int NAX  = 4 * NUM_PLAYERS;
    localparam int NVEC = 2 * NUM_PLAYERS;
    localparam logic signed [8:0] ON_P   = 9'(THRESH_ON);
    localparam logic signed [8:0] ON_N   = 9'(-THRESH_ON);
    localparam logic signed [8:0] OFF_P  = 9'(THRESH_OFF);
    localparam logic signed [8:0] OFF_N  = 9'(-THRESH_OFF);
    localparam logic [3:0]        DB_MAX = 4'(DEBOUNCE);

    function automatic logic signed [8:0] sext(input logic [7:0] raw);
        return {raw[7], raw};
    endfunction

    function automatic logic is_hot(input logic [7:0] raw);
        return (sext(raw) >= ON_P) || (sext(raw) <= ON_N);
    endfunction

    function automatic axis_e axis_next(input axis_e s, input logic [7:0] raw);
        logic signed [8:0] v;
        axis_e n;
        v = sext(raw);
        n = s;
        case (s)
            CENTER: if (v >= ON_P) n = POS; else if (v <= ON_N) n = NEG;
            POS:    if (v <= ON_N) n = NEG; else if (v < OFF_P) n = CENTER;
            NEG:    if (v >= ON_P) n = POS; else if (v > OFF_N) n = CENTER;
            default: n = CENTER;
        endcase
        return n;
    endfunction

    // X positive is right, Y positive is down; packed as {up, down, left, right}.
    function automatic logic [3:0] dir_vec(input axis_e x, input axis_e y);
        return {y == NEG, y == POS, x == NEG, x == POS};
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (v[3] && v[2]) r[3:2] = 2'b00;
        if (v[1] && v[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    axis_e      axis_q [NAX];
    axis_e      axis_d [NAX];
    logic [7:0] axis_raw [NAX];
    logic [3:0] raw_vec [NVEC];
    logic [3:0] cand_q [NVEC];
    logic [3:0] cand_d [NVEC];
    logic [3:0] cnt_q  [NVEC];
    logic [3:0] cnt_d  [NVEC];
    logic [3:0] out_q  [NVEC];
    logic [3:0] out_d  [NVEC];
    logic       hot    [NUM_PLAYERS];
    logic [PW-1:0] ap_q, ap_d;
    logic          act_q, act_d;
    logic          unused_dig;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            axis_raw[4*p]   = joy_l_analog[16*p +: 8];
            axis_raw[4*p+1] = joy_l_analog[16*p+8 +: 8];
            axis_raw[4*p+2] = joy_r_analog[16*p +: 8];
            axis_raw[4*p+3] = joy_r_analog[16*p+8 +: 8];
        end
    end

    always_comb begin
        axis_d = axis_q;
        if (sample_ce) begin
            for (int unsigned a = 0; a < NAX; a++) begin
                axis_d[a] = axis_next(axis_q[a], axis_raw[a]);
            end
        end
    end

    // Raw vectors use the post-update axis state so a new direction counts as its first stable sample.
    always_comb begin : raw_build
        logic [3:0] ana_run;
        logic [3:0] dig;
        logic [3:0] mix;
        ana_run = '0;
        dig     = '0;
        mix     = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            ana_run = dir_vec(axis_d[4*p], axis_d[4*p+1]);
            dig     = joy_dig[32*p +: 4];
            case (mode[2*p +: 2])
                2'd0:    mix = dig;
                2'd1:    mix = ana_run;
                default: mix = dig | ana_run;
            endcase
            raw_vec[2*p]   = socd(mix);
            raw_vec[2*p+1] = socd(dir_vec(axis_d[4*p+2], axis_d[4*p+3]));
        end
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (sample_ce) begin
            for (int unsigned v = 0; v < NVEC; v++) begin
                if (raw_vec[v] == cand_q[v]) begin
                    if (cnt_q[v] != DB_MAX) cnt_d[v] = cnt_q[v] + 4'd1;
                end else begin
                    cand_d[v] = raw_vec[v];
                    cnt_d[v]  = 4'd1;
                end
                if (cnt_d[v] == DB_MAX) out_d[v] = cand_d[v];
            end
        end
    end

    always_comb begin : act_sel
        logic          any_hot;
        logic [PW-1:0] hot_idx;
        any_hot = 1'b0;
        hot_idx = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            hot[p] = (joy_dig[32*p +: 16] != '0) ||
                     is_hot(axis_raw[4*p])   || is_hot(axis_raw[4*p+1]) ||
                     is_hot(axis_raw[4*p+2]) || is_hot(axis_raw[4*p+3]);
            if (!any_hot && hot[p]) begin
                any_hot = 1'b1;
                hot_idx = PW'(p);
            end
        end
        ap_d  = ap_q;
        act_d = 1'b0;
        if (any_hot) begin
            ap_d  = hot_idx;
            act_d = (hot_idx != ap_q);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            axis_q <= '{default: CENTER};
            cand_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            out_q  <= '{default: '0};
            ap_q   <= '0;
            act_q  <= 1'b0;
        end else begin
            axis_q <= axis_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            ap_q   <= ap_d;
            act_q  <= act_d;
        end
    end

    always_comb begin
        run = '0;
        aim = '0;
        unused_dig = 1'b0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            run[4*p +: 4] = out_q[2*p];
            aim[4*p +: 4] = out_q[2*p+1];
            unused_dig    = unused_dig ^ (^joy_dig[32*p+16 +: 16]);
        end
    end

    assign active_player = ap_q;
    assign activity      = act_q;

endmodule

// File: tb/tb_twin_stick_mapper.sv
// Scoreboard bench for twin_stick_mapper: expectations queued with stimulus, popped after each edge.
module tb_twin_stick_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        sample_ce;
    logic [5:0]  mode;
    logic [95:0] joy_dig;
    logic [47:0] joy_l;
    logic [47:0] joy_r;
    logic [11:0] run;
    logic [11:0] aim;
    logic [1:0]  active_player;
    logic        activity;

    typedef struct packed {
        logic [11:0] run;
        logic [11:0] aim;
        logic [1:0]  ap;
        logic        act;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    twin_stick_mapper #(
        .NUM_PLAYERS(3),
        .THRESH_ON(40),
        .THRESH_OFF(24),
        .DEBOUNCE(3),
        .PW(2)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .sample_ce(sample_ce),
        .mode(mode),
        .joy_dig(joy_dig),
        .joy_l_analog(joy_l),
        .joy_r_analog(joy_r),
        .run(run),
        .aim(aim),
        .active_player(active_player),
        .activity(activity)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [3:0] r0, input logic [3:0] a0,
                                input logic [1:0] ap, input logic act);
        exp_t e;
        e.run = {8'h00, r0};
        e.aim = {8'h00, a0};
        e.ap  = ap;
        e.act = act;
        return e;
    endfunction

    task automatic strobe();
        sample_ce = 1'b1;
        @(negedge clk_sys);
        sample_ce = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0; sample_ce = 1'b0; mode = '0;
        joy_dig = '0; joy_l = '0; joy_r = '0;
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0; sample_ce = 1'b1; mode = 6'b101010;
        joy_dig = {32'h0000FFFF, 32'h0000000F, 32'h0};
        joy_l   = {16'h7F7F, 16'h8080, 16'h0};
        joy_r   = {16'h8080, 16'h7F7F, 16'h0};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                reset_n = 1'b1; joy_dig = '0; joy_l = '0; joy_r = '0;
            end
            sb.push_back(mk(4'h0, 4'h0, 2'd0, 1'b0));
            @(negedge clk_sys);
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL reset[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
        sample_ce = 1'b0;
    endtask

    task automatic test_hysteresis();
        logic [7:0] xv [16];
        logic [3:0] rv [16];
        exp_t e;
        xv = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd45, 8'd45, 8'd45, 8'd45,
               8'd30, 8'd30, 8'd30, 8'd30, 8'd20, 8'd20, 8'd20, 8'd20};
        rv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1,
               4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        do_reset();
        mode = 6'b000001;
        for (int i = 0; i < 16; i++) begin
            joy_l[7:0] = xv[i];
            sb.push_back(mk(rv[i], 4'h0, 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL hysteresis[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_thresholds();
        logic [7:0] xv [16];
        logic [3:0] rv [16];
        exp_t e;
        xv = '{8'd39, 8'd39, 8'd39, 8'd39, 8'd40, 8'd40, 8'd40, 8'd40,
               8'd24, 8'd24, 8'd24, 8'd24, 8'd23, 8'd23, 8'd23, 8'd23};
        rv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1,
               4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        do_reset();
        mode = 6'b000001;
        for (int i = 0; i < 16; i++) begin
            joy_l[7:0] = xv[i];
            sb.push_back(mk(rv[i], 4'h0, 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL thresholds[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] xv [8];
        logic [3:0] rv [8];
        exp_t e;
        xv = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        rv = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1};
        do_reset();
        mode = 6'b000001;
        for (int i = 0; i < 8; i++) begin
            joy_l[7:0] = xv[i];
            sb.push_back(mk(rv[i], 4'h0, 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL extremes[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_socd_mode();
        logic [1:0] md [20];
        logic [3:0] dg [20];
        logic [7:0] yv [20];
        logic [3:0] rv [20];
        exp_t e;
        md = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
               2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        dg = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8,
               4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        yv = '{8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd0, 8'd0,
               8'd0, 8'd0, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60};
        rv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
               4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            mode[1:0]     = md[i];
            joy_dig[3:0]  = dg[i];
            joy_l[15:8]   = yv[i];
            sb.push_back(mk(rv[i], 4'h0, 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL socd_mode[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_aim();
        logic [15:0] rs [8];
        logic [3:0]  rv [8];
        logic [3:0]  av [8];
        exp_t e;
        rs = '{16'h46CE, 16'h46CE, 16'h46CE, 16'h46CE, 16'h4632, 16'h4632, 16'h4632, 16'h4632};
        rv = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
        av = '{4'h0, 4'h0, 4'h6, 4'h6, 4'h6, 4'h6, 4'h5, 4'h5};
        do_reset();
        mode = 6'b000010;
        joy_dig[3:0] = 4'h8;
        for (int i = 0; i < 8; i++) begin
            joy_r[15:0] = rs[i];
            sb.push_back(mk(rv[i], av[i], 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL aim[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] xv [8];
        logic [3:0] rv [8];
        exp_t e;
        xv = '{8'd50, 8'd50, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd50};
        rv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        do_reset();
        mode = 6'b000001;
        for (int i = 0; i < 8; i++) begin
            joy_l[7:0] = xv[i];
            sb.push_back(mk(rv[i], 4'h0, 2'd0, 1'b0));
            strobe();
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL glitch[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    task automatic test_priority();
        logic [95:0] dg [11];
        logic [47:0] ls [11];
        logic [47:0] rs [11];
        logic [1:0]  apv [11];
        logic        acv [11];
        exp_t e;
        dg = '{{32'h10, 32'h0, 32'h0}, {32'h10, 32'h0, 32'h0}, {32'h10, 32'h0, 32'h0},
               {32'h10, 32'h0, 32'h0}, 96'h0, 96'h0, 96'h0, 96'h0,
               {32'h0, 32'h8000, 32'h0}, {32'h00010000, 32'h0, 32'h0}, 96'h0};
        ls = '{48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0,
               {16'h0, 16'h0027, 16'h0}, {16'h0, 16'h00D8, 16'h0}, 48'h0, 48'h0, 48'h0};
        rs = '{48'h0, 48'h0, {32'h0, 16'h6400}, {32'h0, 16'h6400}, 48'h0, 48'h0,
               48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
        apv = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        acv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            joy_dig = dg[i];
            joy_l   = ls[i];
            joy_r   = rs[i];
            sb.push_back(mk(4'h0, 4'h0, apv[i], acv[i]));
            @(negedge clk_sys);
            e = sb.pop_front();
            checks++;
            if (run !== e.run || aim !== e.aim || active_player !== e.ap || activity !== e.act) begin
                failures++;
                $display("FAIL priority[%0d]: got run=%h aim=%h ap=%0d act=%b, want run=%h aim=%h ap=%0d act=%b",
                         i, run, aim, active_player, activity, e.run, e.aim, e.ap, e.act);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_thresholds();
        test_extremes();
        test_socd_mode();
        test_aim();
        test_glitch();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
